// File: rtl/regfile_mp_pkg.sv
// Shared core constants for the multi-port register file and its scoreboard.
package regfile_mp_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int NREG_DEF   = 32;
  localparam int NWP_DEF    = 2;
  localparam bit BYPASS_DEF = 1'b1;

  // Architectural register that is hardwired to zero.
  localparam int REG_ZERO = 0;

  // True when the address names the hardwired zero register.
  function automatic bit is_reg_zero(input int unsigned addr);
    return addr == REG_ZERO;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between decode/writeback and the register file.
// There is no handshake on this bundle: every field is sampled on every
// rising clock edge, nothing is ever stalled, and read/busy outputs are
// purely combinational functions of the current inputs and stored state.
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NWP  = NWP_DEF
);
  localparam int AW = $clog2(NREG);

  logic [NWP-1:0]      rf_we;
  logic [NWP*AW-1:0]   rf_waddr;
  logic [NWP*XLEN-1:0] rf_din;
  logic [AW-1:0]       rf_raddr_rs1;
  logic [AW-1:0]       rf_raddr_rs2;
  logic [XLEN-1:0]     rf_dout_rs1;
  logic [XLEN-1:0]     rf_dout_rs2;
  logic                sb_set;
  logic [AW-1:0]       sb_addr;
  logic                sb_flush;
  logic                sb_busy_rs1;
  logic                sb_busy_rs2;

  modport master (
    output rf_we, rf_waddr, rf_din, rf_raddr_rs1, rf_raddr_rs2,
    output sb_set, sb_addr, sb_flush,
    input  rf_dout_rs1, rf_dout_rs2, sb_busy_rs1, sb_busy_rs2
  );

  modport slave (
    input  rf_we, rf_waddr, rf_din, rf_raddr_rs1, rf_raddr_rs2,
    input  sb_set, sb_addr, sb_flush,
    output rf_dout_rs1, rf_dout_rs2, sb_busy_rs1, sb_busy_rs2
  );

endinterface

// File: rtl/regfile_mp_sb.sv
// Busy-bit scoreboard: one bit per register, set at issue, cleared by any
// writeback to that register, all cleared by a pipeline flush.
// Priority per edge: flush > set > writeback clear. Bit 0 is always 0.
module regfile_mp_sb
  import regfile_mp_pkg::*;
#(
  parameter  int NREG = NREG_DEF,
  parameter  int NWP  = NWP_DEF,
  localparam int AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NWP-1:0]    wr_en,
  input  logic [NWP*AW-1:0] wr_addr,
  input  logic              sb_set,
  input  logic [AW-1:0]     sb_addr,
  input  logic              sb_flush,
  input  logic [AW-1:0]     rd_addr_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic              busy_a,
  output logic              busy_b
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] clr_vec;

  // Registers targeted by any enabled write port this cycle.
  always_comb begin
    clr_vec = '0;
    for (int p = 0; p < NWP; p++) begin
      if (wr_en[p]) clr_vec[wr_addr[p*AW +: AW]] = 1'b1;
    end
  end

  // Next busy state: clear, then set (new producer wins), then flush.
  always_comb begin
    busy_d = busy_q & ~clr_vec;
    if (sb_set) busy_d[sb_addr] = 1'b1;
    if (sb_flush) busy_d = '0;
    busy_d[REG_ZERO] = 1'b0;
  end

  // Busy state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // Lookups see registered state only; no same-cycle forwarding.
  assign busy_a = busy_q[rd_addr_a];
  assign busy_b = busy_q[rd_addr_b];

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: two combinational read ports, NWP
// synchronous write ports (highest-index port wins on an address clash),
// optional same-cycle write-to-read forwarding, and a busy scoreboard.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NWP    = NWP_DEF,
  parameter bit BYPASS = BYPASS_DEF
) (
  input  logic         clk,
  input  logic         rstn,
  regfile_mp_if.slave  rf
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs [NREG];
  logic [AW-1:0]   waddr [NWP];
  logic [XLEN-1:0] wdata [NWP];
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;

  // Split the packed write buses into per-port fields.
  for (genvar p = 0; p < NWP; p++) begin : g_wport
    assign waddr[p] = rf.rf_waddr[p*AW +: AW];
    assign wdata[p] = rf.rf_din[p*XLEN +: XLEN];
  end

  // Array update; later ports overwrite earlier ones, so the highest
  // enabled port lands when several target the same register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      for (int p = 0; p < NWP; p++) begin
        if (rf.rf_we[p] && !is_reg_zero(32'(waddr[p]))) regs[waddr[p]] <= wdata[p];
      end
    end
  end

  // Read mux: array value, overridden by the highest matching write port
  // when forwarding is enabled and not in reset; register 0 forced to 0.
  always_comb begin
    rd1 = regs[rf.rf_raddr_rs1];
    rd2 = regs[rf.rf_raddr_rs2];
    if (BYPASS && rstn) begin
      for (int p = 0; p < NWP; p++) begin
        if (rf.rf_we[p] && waddr[p] == rf.rf_raddr_rs1) rd1 = wdata[p];
        if (rf.rf_we[p] && waddr[p] == rf.rf_raddr_rs2) rd2 = wdata[p];
      end
    end
    if (is_reg_zero(32'(rf.rf_raddr_rs1))) rd1 = '0;
    if (is_reg_zero(32'(rf.rf_raddr_rs2))) rd2 = '0;
  end

  assign rf.rf_dout_rs1 = rd1;
  assign rf.rf_dout_rs2 = rd2;

  regfile_mp_sb #(
    .NREG (NREG),
    .NWP  (NWP)
  ) u_sb (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en     (rf.rf_we),
    .wr_addr   (rf.rf_waddr),
    .sb_set    (rf.sb_set),
    .sb_addr   (rf.sb_addr),
    .sb_flush  (rf.sb_flush),
    .rd_addr_a (rf.rf_raddr_rs1),
    .rd_addr_b (rf.rf_raddr_rs2),
    .busy_a    (rf.sb_busy_rs1),
    .busy_b    (rf.sb_busy_rs2)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a forwarding instance (u_dut) and a
// non-forwarding instance (u_dut_nb) driven by identical inputs.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NWP  = 2;
  localparam int AW   = 5;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NWP(NWP)) rf_a ();
  regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NWP(NWP)) rf_b ();

  assign rf_b.rf_we        = rf_a.rf_we;
  assign rf_b.rf_waddr     = rf_a.rf_waddr;
  assign rf_b.rf_din       = rf_a.rf_din;
  assign rf_b.rf_raddr_rs1 = rf_a.rf_raddr_rs1;
  assign rf_b.rf_raddr_rs2 = rf_a.rf_raddr_rs2;
  assign rf_b.sb_set       = rf_a.sb_set;
  assign rf_b.sb_addr      = rf_a.sb_addr;
  assign rf_b.sb_flush     = rf_a.sb_flush;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NWP(NWP), .BYPASS(1'b1)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .rf   (rf_a)
  );

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NWP(NWP), .BYPASS(1'b0)) u_dut_nb (
    .clk  (clk),
    .rstn (rstn),
    .rf   (rf_b)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    rf_a.rf_we    = '0;
    rf_a.rf_waddr = '0;
    rf_a.rf_din   = '0;
    rf_a.sb_set   = 1'b0;
    rf_a.sb_addr  = '0;
    rf_a.sb_flush = 1'b0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] addr, input logic [XLEN-1:0] data);
    rf_a.rf_we[p]               = 1'b1;
    rf_a.rf_waddr[p*AW +: AW]   = addr;
    rf_a.rf_din[p*XLEN +: XLEN] = data;
  endtask

  task automatic set_busy(input logic [AW-1:0] addr);
    rf_a.sb_set  = 1'b1;
    rf_a.sb_addr = addr;
  endtask

  task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    rf_a.rf_raddr_rs1 = a1;
    rf_a.rf_raddr_rs2 = a2;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    idle();
    rd(5'd5, 5'd5);
    repeat (2) tick();
    chk("rst_dout", rf_a.rf_dout_rs1, 32'h0);
    chk("rst_busy", {31'b0, rf_a.sb_busy_rs1}, 32'h0);
    tick();
    rstn = 1'b1;

    // Write x5 and mark it busy, then reset mid-cycle
    wr(0, 5'd5, 32'hDEADBEEF);
    set_busy(5'd5);
    settle();
    chk("byp_x5", rf_a.rf_dout_rs1, 32'hDEADBEEF);
    chk("nobyp_x5_old", rf_b.rf_dout_rs1, 32'h0);
    tick();
    idle();
    settle();
    chk("x5_after", rf_a.rf_dout_rs1, 32'hDEADBEEF);
    chk("nb_x5_after", rf_b.rf_dout_rs1, 32'hDEADBEEF);
    chk("x5_busy_set_wins", {31'b0, rf_a.sb_busy_rs1}, 32'h1);
    #3;
    rstn = 1'b0;
    settle();
    chk("rst_mid_dout", rf_a.rf_dout_rs1, 32'h0);
    chk("rst_mid_dout_nb", rf_b.rf_dout_rs1, 32'h0);
    chk("rst_mid_busy", {31'b0, rf_a.sb_busy_rs1}, 32'h0);
    wr(0, 5'd5, 32'h00001234);
    settle();
    chk("rst_no_byp", rf_a.rf_dout_rs1, 32'h0);
    tick();
    idle();
    tick();
    rstn = 1'b1;
    settle();
    chk("post_rst_dout", rf_a.rf_dout_rs1, 32'h0);
    chk("post_rst_busy", {31'b0, rf_a.sb_busy_rs1}, 32'h0);
    tick();
    chk("post_rst_dout2", rf_a.rf_dout_rs1, 32'h0);

    // Zero register ignores writes and scoreboard sets
    wr(0, 5'd0, 32'hFFFFFFFF);
    set_busy(5'd0);
    rd(5'd0, 5'd0);
    settle();
    chk("x0_byp", rf_a.rf_dout_rs1, 32'h0);
    tick();
    idle();
    settle();
    chk("x0_read", rf_a.rf_dout_rs1, 32'h0);
    chk("x0_read_nb", rf_b.rf_dout_rs1, 32'h0);
    chk("x0_busy", {31'b0, rf_a.sb_busy_rs1}, 32'h0);

    // Same-address conflict: port 1 wins
    wr(0, 5'd7, 32'h11);
    wr(1, 5'd7, 32'h22);
    rd(5'd7, 5'd7);
    settle();
    chk("conf_byp_rs1", rf_a.rf_dout_rs1, 32'h22);
    chk("conf_byp_rs2", rf_a.rf_dout_rs2, 32'h22);
    chk("conf_nobyp_old", rf_b.rf_dout_rs1, 32'h0);
    tick();
    idle();
    settle();
    chk("conf_after", rf_a.rf_dout_rs1, 32'h22);
    chk("conf_after_nb", rf_b.rf_dout_rs1, 32'h22);

    // Independent dual-port writes
    wr(0, 5'd3, 32'hA);
    wr(1, 5'd4, 32'hB);
    rd(5'd3, 5'd4);
    tick();
    idle();
    settle();
    chk("dual_rs1", rf_a.rf_dout_rs1, 32'hA);
    chk("dual_rs2", rf_a.rf_dout_rs2, 32'hB);
    chk("dual_rs1_nb", rf_b.rf_dout_rs1, 32'hA);
    chk("dual_rs2_nb", rf_b.rf_dout_rs2, 32'hB);

    // Scoreboard set / writeback clear / set beats clear
    set_busy(5'd9);
    rd(5'd9, 5'd9);
    settle();
    chk("sb_no_fwd", {31'b0, rf_a.sb_busy_rs1}, 32'h0);
    tick();
    idle();
    settle();
    chk("sb_set_rs1", {31'b0, rf_a.sb_busy_rs1}, 32'h1);
    chk("sb_set_rs2", {31'b0, rf_a.sb_busy_rs2}, 32'h1);
    wr(1, 5'd9, 32'h99);
    settle();
    chk("sb_clr_pending", {31'b0, rf_a.sb_busy_rs1}, 32'h1);
    tick();
    idle();
    settle();
    chk("sb_clr", {31'b0, rf_a.sb_busy_rs1}, 32'h0);
    chk("sb_clr_nb", {31'b0, rf_b.sb_busy_rs2}, 32'h0);
    set_busy(5'd9);
    wr(0, 5'd9, 32'h55);
    tick();
    idle();
    settle();
    chk("sb_set_beats_clr", {31'b0, rf_a.sb_busy_rs1}, 32'h1);
    chk("x9_data", rf_a.rf_dout_rs1, 32'h55);

    // Flush beats set and clears everything
    set_busy(5'd1);
    tick();
    set_busy(5'd2);
    tick();
    set_busy(5'd3);
    tick();
    idle();
    rd(5'd1, 5'd3);
    settle();
    chk("fl_pre_x1", {31'b0, rf_a.sb_busy_rs1}, 32'h1);
    chk("fl_pre_x3", {31'b0, rf_a.sb_busy_rs2}, 32'h1);
    rf_a.sb_flush = 1'b1;
    set_busy(5'd4);
    tick();
    idle();
    settle();
    chk("fl_x1", {31'b0, rf_a.sb_busy_rs1}, 32'h0);
    chk("fl_x3", {31'b0, rf_a.sb_busy_rs2}, 32'h0);
    rd(5'd4, 5'd2);
    settle();
    chk("fl_x4", {31'b0, rf_a.sb_busy_rs1}, 32'h0);
    chk("fl_x2", {31'b0, rf_a.sb_busy_rs2}, 32'h0);
    rd(5'd9, 5'd4);
    settle();
    chk("fl_x9", {31'b0, rf_a.sb_busy_rs1}, 32'h0);
    set_busy(5'd4);
    tick();
    idle();
    settle();
    chk("x4_set_after_fl", {31'b0, rf_a.sb_busy_rs2}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
